// File: rtl/clk_tick_monitor.sv
// Divided-clock period monitor: measures MON_IN rise-to-rise period in CLK
// cycles, locks after consecutive good periods, flags off-frequency/missing edges.
//
// Ports:
//   CLK          block clock; MON_IN is sampled here
//   RST_N        asynchronous active-low reset
//   MON_IN       monitored clock, asynchronous to CLK
//   CLR          sync pulse clearing ERR_STICKY and ERR_COUNT
//   PERIOD       last measured period in CLK cycles
//   PERIOD_VALID 1-cycle pulse when PERIOD updates
//   LOCKED       high while the FSM is in LOCK (registered)
//   MISSING      no rising edge seen for 2*EXP_PERIOD cycles
//   ERR_STICKY   set on any fault, cleared by CLR
//   ERR_COUNT    saturating fault counter
module clk_tick_monitor #(
  parameter int unsigned EXP_PERIOD = 44,
  parameter int unsigned TOL        = 2,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             MON_IN,
  input  logic             CLR,
  output logic [CNT_W-1:0] PERIOD,
  output logic             PERIOD_VALID,
  output logic             LOCKED,
  output logic             MISSING,
  output logic             ERR_STICKY,
  output logic [7:0]       ERR_COUNT
);

  localparam int unsigned GC_W = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0] P_LO  = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0] P_HI  = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] P_TMO = CNT_W'(2 * EXP_PERIOD);
  localparam logic [CNT_W-1:0] P_MAX = '1;
  localparam logic [GC_W-1:0]  GC_LK = GC_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GC_W-1:0]  gc_q, gc_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pv_q, pv_d;
  logic             locked_q, locked_d;
  logic             missing_q, missing_d;
  logic             sticky_q, sticky_d;
  logic [7:0]       ecnt_q, ecnt_d;

  logic rise, good, tmo, fault;

  always_comb begin
    rise = s2_q & ~s3_q;
    good = (cnt_q >= P_LO) && (cnt_q <= P_HI);
    // cnt keeps running past P_TMO, so this fires once per gap
    tmo  = (cnt_q == P_TMO) && !rise;

    if (rise)
      cnt_d = CNT_W'(1);
    else if (cnt_q == P_MAX)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + CNT_W'(1);

    missing_d = missing_q;
    if (rise)
      missing_d = 1'b0;
    else if (tmo)
      missing_d = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    gc_d     = gc_q;
    period_d = period_q;
    pv_d     = 1'b0;
    fault    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = ACQ;
          gc_d    = '0;
        end
      end
      ACQ: begin
        if (rise) begin
          period_d = cnt_q;
          pv_d     = 1'b1;
          if (good) begin
            gc_d = gc_q + GC_W'(1);
            if (gc_q + GC_W'(1) == GC_LK)
              state_d = LOCK;
          end else begin
            gc_d  = '0;
            fault = 1'b1;
          end
        end else if (tmo) begin
          state_d = IDLE;
          gc_d    = '0;
          fault   = 1'b1;
        end
      end
      LOCK: begin
        if (rise) begin
          period_d = cnt_q;
          pv_d     = 1'b1;
          if (!good) begin
            state_d = ACQ;
            gc_d    = '0;
            fault   = 1'b1;
          end
        end else if (tmo) begin
          state_d = IDLE;
          gc_d    = '0;
          fault   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gc_d    = '0;
      end
    endcase

    locked_d = (state_q == LOCK);

    // a fault coinciding with CLR survives as the first new fault
    sticky_d = sticky_q;
    ecnt_d   = ecnt_q;
    if (CLR) begin
      sticky_d = fault;
      ecnt_d   = fault ? 8'd1 : 8'd0;
    end else if (fault) begin
      sticky_d = 1'b1;
      if (ecnt_q != 8'hFF)
        ecnt_d = ecnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      gc_q      <= '0;
      period_q  <= '0;
      pv_q      <= 1'b0;
      locked_q  <= 1'b0;
      missing_q <= 1'b0;
      sticky_q  <= 1'b0;
      ecnt_q    <= '0;
    end else begin
      s1_q      <= MON_IN;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gc_q      <= gc_d;
      period_q  <= period_d;
      pv_q      <= pv_d;
      locked_q  <= locked_d;
      missing_q <= missing_d;
      sticky_q  <= sticky_d;
      ecnt_q    <= ecnt_d;
    end
  end

  assign PERIOD       = period_q;
  assign PERIOD_VALID = pv_q;
  assign LOCKED       = locked_q;
  assign MISSING      = missing_q;
  assign ERR_STICKY   = sticky_q;
  assign ERR_COUNT    = ecnt_q;

endmodule
